// File: rtl/simple_cpu_mc_if.sv
// Instruction handshake bundle for simple_cpu_mc.
//   instruction  : instruction word, master -> CPU
//   instr_valid  : instruction present, master -> CPU
//   instr_ready  : CPU idle and able to accept, CPU -> master
//   busy         : instruction in flight, CPU -> master
//   done         : one-cycle pulse on the final cycle of an instruction, CPU -> master
interface simple_cpu_mc_if #(
   parameter int INSTR_WIDTH = 20
);
   logic [INSTR_WIDTH-1:0] instruction;
   logic                   instr_valid;
   logic                   instr_ready;
   logic                   busy;
   logic                   done;

   modport master (
      output instruction, instr_valid,
      input  instr_ready, busy, done
   );

   modport slave (
      input  instruction, instr_valid,
      output instr_ready, busy, done
   );
endinterface

// File: rtl/simple_cpu_mc.sv
// Multi-cycle CPU: executes one externally supplied instruction at a time
// through IDLE -> DECODE -> EXEC -> MEM -> WB.
//   clk, rst       : rising-edge clock, asynchronous active-low reset
//   bus            : instruction handshake (slave side)
//   flag_zero      : last R-type result was zero
//   flag_carry     : last ADD carry-out / SUB borrow (cleared by other R-type ops)
//   dbg_reg_addr/data : combinational register-file read
//   dbg_mem_addr/data : combinational data-memory read
// The INSTR_WIDTH parameter must match the interface instance.
module simple_cpu_mc #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_BITS   = 5,
   parameter int REG_BITS    = 2,
   parameter int INSTR_WIDTH = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   simple_cpu_mc_if.slave        bus,
   output logic                  flag_zero,
   output logic                  flag_carry,
   input  logic [REG_BITS-1:0]   dbg_reg_addr,
   output logic [DATA_WIDTH-1:0] dbg_reg_data,
   input  logic [ADDR_BITS-1:0]  dbg_mem_addr,
   output logic [DATA_WIDTH-1:0] dbg_mem_data
);
   localparam int NREG    = 1 << REG_BITS;
   localparam int NMEM    = 1 << ADDR_BITS;
   localparam int FIELD_W = (ADDR_BITS > DATA_WIDTH) ? ADDR_BITS : DATA_WIDTH;

   if (INSTR_WIDTH < 6 + 3*REG_BITS + FIELD_W) begin : g_bad_width
      $error("simple_cpu_mc: INSTR_WIDTH too small for REG_BITS/ADDR_BITS/DATA_WIDTH");
   end

   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

   localparam logic [1:0] OP_LDI = 2'b00;
   localparam logic [1:0] OP_R   = 2'b01;
   localparam logic [1:0] OP_ST  = 2'b11;

   state_t                  state_q, state_d;
   logic [INSTR_WIDTH-1:0]  ir_q, ir_d;
   logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
   logic [DATA_WIDTH-1:0]   res_q, res_d;
   logic                    alu_c_q, alu_c_d;
   logic [ADDR_BITS-1:0]    addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   regs_q [NREG];
   logic [DATA_WIDTH-1:0]   regs_d [NREG];
   logic [DATA_WIDTH-1:0]   mem_q  [NMEM];
   logic [DATA_WIDTH-1:0]   mem_d  [NMEM];
   logic                    zero_q, zero_d, carry_q, carry_d;
   logic                    ready_q, ready_d, busy_q, busy_d, done_q, done_d;

   // instruction fields, always taken from the latched word
   logic [1:0]            op;
   logic [REG_BITS-1:0]   x1, x2, x3;
   logic [2:0]            funct;
   logic [ADDR_BITS-1:0]  offset;
   logic [DATA_WIDTH-1:0] imm;
   logic                  unused_ir;

   assign op        = ir_q[INSTR_WIDTH-1 -: 2];
   assign x1        = ir_q[INSTR_WIDTH-3 -: REG_BITS];
   assign x2        = ir_q[INSTR_WIDTH-3-REG_BITS -: REG_BITS];
   assign x3        = ir_q[INSTR_WIDTH-3-2*REG_BITS -: REG_BITS];
   assign funct     = ir_q[2:0];
   assign offset    = ir_q[ADDR_BITS+3:4];
   assign imm       = ir_q[DATA_WIDTH+3:4];
   assign unused_ir = ^ir_q;

   // ALU on registered operands (a = X2, b = X3)
   logic [DATA_WIDTH-1:0] alu_res;
   logic                  alu_cout;

   always_comb begin
      alu_res  = '0;
      alu_cout = 1'b0;
      case (funct)
         3'b000:  {alu_cout, alu_res} = {1'b0, a_q} + {1'b0, b_q};
         3'b001:  {alu_cout, alu_res} = {1'b0, a_q} - {1'b0, b_q};  // bit DATA_WIDTH is the borrow
         3'b010:  alu_res = a_q & b_q;
         3'b011:  alu_res = a_q | b_q;
         3'b100:  alu_res = a_q ^ b_q;
         3'b101:  alu_res = {a_q[DATA_WIDTH-2:0], 1'b0};
         3'b110:  alu_res = {1'b0, a_q[DATA_WIDTH-1:1]};
         default: alu_res = a_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      res_d   = res_q;
      alu_c_d = alu_c_q;
      addr_d  = addr_q;
      regs_d  = regs_q;
      mem_d   = mem_q;
      zero_d  = zero_q;
      carry_d = carry_q;

      case (state_q)
         S_IDLE: begin
            if (bus.instr_valid) begin
               ir_d    = bus.instruction;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d = regs_q[x2];
            b_d = regs_q[x3];
            c_d = regs_q[x1];
            if (op == OP_LDI) begin
               res_d   = imm;
               state_d = S_WB;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            res_d   = alu_res;
            alu_c_d = alu_cout;
            // zero-extend both terms so the add is correct for any DATA_WIDTH/ADDR_BITS mix
            addr_d  = ADDR_BITS'({{ADDR_BITS{1'b0}}, a_q} + {{DATA_WIDTH{1'b0}}, offset});
            state_d = (op == OP_R) ? S_WB : S_MEM;
         end
         S_MEM: begin
            if (op == OP_ST) begin
               mem_d[addr_q] = c_q;
               state_d       = S_IDLE;
            end else begin
               res_d   = mem_q[addr_q];
               state_d = S_WB;
            end
         end
         S_WB: begin
            regs_d[x1] = res_q;
            if (op == OP_R) begin
               zero_d  = (res_q == '0);
               carry_d = alu_c_q;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // outputs registered from the next state so they line up with state_q
      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_WB) || (state_d == S_MEM && op == OP_ST);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         res_q   <= '0;
         alu_c_q <= 1'b0;
         addr_q  <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= DATA_WIDTH'(i);
         for (int i = 0; i < NMEM; i++) mem_q[i]  <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         res_q   <= res_d;
         alu_c_q <= alu_c_d;
         addr_q  <= addr_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         regs_q  <= regs_d;
         mem_q   <= mem_d;
      end
   end

   assign bus.instr_ready = ready_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign flag_zero       = zero_q;
   assign flag_carry      = carry_q;
   assign dbg_reg_data    = regs_q[dbg_reg_addr];
   assign dbg_mem_data    = mem_q[dbg_mem_addr];
endmodule
